// File: rtl/ch3_wt_encoder.sv
// ch3_wt_encoder: parses a 5-character ASCII time frame ("HHMMa") into
// 4-bit display codes. Characters are validated per position, collected in
// shadow registers, and published to the outputs in a single commit cycle.
//
// Handshake: a character is consumed on a rising CLK edge where
// CHAR_VALID=1 and CHAR_READY=1. CHAR_READY drops only for the one commit
// cycle (S_DONE), so a producer holding CHAR_VALID high simply waits.
module ch3_wt_encoder (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] CHAR_IN,
    input  logic       CHAR_VALID,
    output logic       CHAR_READY,
    output logic [3:0] HOUR_T,
    output logic [3:0] HOUR_U,
    output logic [3:0] MIN_T,
    output logic [3:0] MIN_U,
    output logic [3:0] AMPM,
    output logic       TIME_VALID,
    output logic       ERR
);

    typedef enum logic [2:0] {
        S_HT   = 3'd0,
        S_HU   = 3'd1,
        S_MT   = 3'd2,
        S_MU   = 3'd3,
        S_AP   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [3:0] C_AM    = 4'b1010;
    localparam logic [3:0] C_PM    = 4'b1100;
    localparam logic [3:0] C_BLANK = 4'b1101;

    state_t     r_state;
    logic [3:0] r_sh_ht;
    logic [3:0] r_sh_hu;
    logic [3:0] r_sh_mt;
    logic [3:0] r_sh_mu;
    logic [3:0] r_sh_ap;
    logic [3:0] r_hour_t;
    logic [3:0] r_hour_u;
    logic [3:0] r_min_t;
    logic [3:0] r_min_u;
    logic [3:0] r_ampm;
    logic       r_time_valid;
    logic       r_err;

    logic [3:0] w_code;
    logic       w_is_digit;
    logic       w_is_blank;
    logic       w_is_ampm;
    logic       w_legal;
    logic       w_ready;
    logic       w_accept;

    assign w_ready    = (r_state != S_DONE);
    assign w_accept   = CHAR_VALID && w_ready;

    assign CHAR_READY = w_ready;
    assign HOUR_T     = r_hour_t;
    assign HOUR_U     = r_hour_u;
    assign MIN_T      = r_min_t;
    assign MIN_U      = r_min_u;
    assign AMPM       = r_ampm;
    assign TIME_VALID = r_time_valid;
    assign ERR        = r_err;

    // Map the incoming byte to its 4-bit code and classify it.
    always_comb begin
        w_code     = 4'h0;
        w_is_digit = 1'b0;
        w_is_blank = 1'b0;
        w_is_ampm  = 1'b0;
        if (CHAR_IN >= 8'h30 && CHAR_IN <= 8'h39) begin
            w_is_digit = 1'b1;
            w_code     = CHAR_IN[3:0];
        end else if (CHAR_IN == 8'h41) begin
            w_is_ampm  = 1'b1;
            w_code     = C_AM;
        end else if (CHAR_IN == 8'h50) begin
            w_is_ampm  = 1'b1;
            w_code     = C_PM;
        end else if (CHAR_IN == 8'h20) begin
            w_is_blank = 1'b1;
            w_code     = C_BLANK;
        end
    end

    // Decide whether the current character is legal at the current position;
    // the hour-units check also enforces the 1..12 hour range.
    always_comb begin
        w_legal = 1'b0;
        case (r_state)
            S_HT: w_legal = w_is_blank || (w_is_digit && w_code <= 4'd1);
            S_HU: w_legal = w_is_digit
                            && !(((r_sh_ht == C_BLANK) || (r_sh_ht == 4'h0)) && (w_code == 4'h0))
                            && !((r_sh_ht == 4'h1) && (w_code > 4'd2));
            S_MT: w_legal = w_is_digit && w_code <= 4'd5;
            S_MU: w_legal = w_is_digit;
            S_AP: w_legal = w_is_ampm;
            default: w_legal = 1'b0;
        endcase
    end

    // Frame FSM: collect codes in shadows, commit in S_DONE, abort on errors.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state      <= S_HT;
            r_sh_ht      <= 4'h0;
            r_sh_hu      <= 4'h0;
            r_sh_mt      <= 4'h0;
            r_sh_mu      <= 4'h0;
            r_sh_ap      <= 4'h0;
            r_hour_t     <= 4'h1;
            r_hour_u     <= 4'h2;
            r_min_t      <= 4'h0;
            r_min_u      <= 4'h0;
            r_ampm       <= C_AM;
            r_time_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_time_valid <= 1'b0;
            r_err        <= 1'b0;
            if (r_state == S_DONE) begin
                r_hour_t     <= r_sh_ht;
                r_hour_u     <= r_sh_hu;
                r_min_t      <= r_sh_mt;
                r_min_u      <= r_sh_mu;
                r_ampm       <= r_sh_ap;
                r_time_valid <= 1'b1;
                r_state      <= S_HT;
            end else if (w_accept) begin
                if (!w_legal) begin
                    // Offending character is consumed; the frame restarts.
                    r_err   <= 1'b1;
                    r_state <= S_HT;
                    r_sh_ht <= 4'h0;
                    r_sh_hu <= 4'h0;
                    r_sh_mt <= 4'h0;
                    r_sh_mu <= 4'h0;
                    r_sh_ap <= 4'h0;
                end else begin
                    case (r_state)
                        S_HT: begin
                            r_sh_ht <= w_code;
                            r_state <= S_HU;
                        end
                        S_HU: begin
                            r_sh_hu <= w_code;
                            r_state <= S_MT;
                        end
                        S_MT: begin
                            r_sh_mt <= w_code;
                            r_state <= S_MU;
                        end
                        S_MU: begin
                            r_sh_mu <= w_code;
                            r_state <= S_AP;
                        end
                        S_AP: begin
                            r_sh_ap <= w_code;
                            r_state <= S_DONE;
                        end
                        default: r_state <= S_HT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ch3_wt_encoder.sv
// Bench for ch3_wt_encoder: table of directed frames, reset-mid-frame and
// back-to-back sequences, and random frames/junk, all scored cycle by cycle
// against a character-level frame model.
module tb_ch3_wt_encoder;

    typedef logic [7:0] ch_t;

    typedef struct {
        string       s;
        int          n_tv;
        int          n_err;
        logic [19:0] t;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic [7:0] CHAR_IN = 8'h00;
    logic       CHAR_VALID = 1'b0;
    logic       CHAR_READY;
    logic [3:0] HOUR_T, HOUR_U, MIN_T, MIN_U, AMPM;
    logic       TIME_VALID, ERR;

    ch3_wt_encoder dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .CHAR_IN    (CHAR_IN),
        .CHAR_VALID (CHAR_VALID),
        .CHAR_READY (CHAR_READY),
        .HOUR_T     (HOUR_T),
        .HOUR_U     (HOUR_U),
        .MIN_T      (MIN_T),
        .MIN_U      (MIN_U),
        .AMPM       (AMPM),
        .TIME_VALID (TIME_VALID),
        .ERR        (ERR)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          tv_seen = 0;
    int          err_seen = 0;
    int          rdy_low_seen = 0;
    logic [19:0] cur_time = 20'h1200A;
    logic [19:0] exp_q[$];
    int          exp_cyc_q[$];
    bit          exp_tv[int];
    bit          exp_err[int];
    bit          exp_busy[int];
    ch_t         frame_q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_digit(ch_t c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic logic [3:0] code_of(ch_t c);
        if (is_digit(c)) return 4'(int'(c) - int'("0"));
        if (c == "A") return 4'hA;
        if (c == "P") return 4'hC;
        return 4'hD;
    endfunction

    function automatic void model_reset();
        frame_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
        exp_tv.delete();
        exp_err.delete();
        exp_busy.delete();
        cur_time = 20'h1200A;
    endfunction

    // Called in the cycle before the edge that consumes c.
    function automatic void model_accept(ch_t c);
        int pos;
        int hour;
        int at;
        bit ok;
        frame_q.push_back(c);
        pos = frame_q.size() - 1;
        at  = cyc + 1;
        ok  = 1'b0;
        case (pos)
            0: ok = (c == " ") || (c == "0") || (c == "1");
            1: begin
                ok = is_digit(c);
                if (ok) begin
                    hour = (frame_q[0] == " " ? 0 : int'(frame_q[0]) - int'("0")) * 10
                           + int'(c) - int'("0");
                    ok = (hour >= 1) && (hour <= 12);
                end
            end
            2: ok = (c >= "0") && (c <= "5");
            3: ok = is_digit(c);
            4: ok = (c == "A") || (c == "P");
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            exp_err[at] = 1'b1;
            frame_q.delete();
        end else if (pos == 4) begin
            exp_busy[at]   = 1'b1;
            exp_tv[at + 1] = 1'b1;
            exp_q.push_back({code_of(frame_q[0]), code_of(frame_q[1]), code_of(frame_q[2]),
                             code_of(frame_q[3]), code_of(frame_q[4])});
            exp_cyc_q.push_back(at + 1);
            frame_q.delete();
        end
    endfunction

    // ---------------- monitor: per-cycle comparison ----------------
    always @(negedge CLK) begin
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            cur_time = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
        end
        check("TIME_VALID", 32'(TIME_VALID), 32'(exp_tv.exists(cyc)));
        check("ERR", 32'(ERR), 32'(exp_err.exists(cyc)));
        check("CHAR_READY", 32'(CHAR_READY), 32'(!exp_busy.exists(cyc)));
        check("time_out", 32'({HOUR_T, HOUR_U, MIN_T, MIN_U, AMPM}), 32'(cur_time));
        if (TIME_VALID) tv_seen++;
        if (ERR) err_seen++;
        if (!CHAR_READY) rdy_low_seen++;
    end

    // ---------------- driver tasks (called at negedge+1) ----------------
    task automatic drive_char(ch_t c, bit rnd);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        while (!done) begin
            CHAR_VALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            CHAR_IN    = CHAR_VALID ? c : 8'($urandom_range(0, 255));
            if (CHAR_VALID && CHAR_READY) begin
                model_accept(c);
                done = 1'b1;
            end
            @(negedge CLK);
            #1;
            n++;
            if (!done && n > 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: char %0h not accepted after %0d cycles", c, n);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_str(string s, bit rnd);
        for (int i = 0; i < s.len(); i++) drive_char(ch_t'(s[i]), rnd);
    endtask

    task automatic idle(int n);
        CHAR_VALID = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic clear_counts();
        tv_seen = 0;
        err_seen = 0;
        rdy_low_seen = 0;
    endtask

    task automatic send_rand_frame(bit rnd);
        int  h;
        int  m;
        ch_t f[5];
        h = $urandom_range(1, 12);
        m = $urandom_range(0, 59);
        f[0] = (h >= 10) ? "1" : ($urandom_range(0, 1) ? " " : "0");
        f[1] = 8'(int'("0") + h % 10);
        f[2] = 8'(int'("0") + m / 10);
        f[3] = 8'(int'("0") + m % 10);
        f[4] = $urandom_range(0, 1) ? "A" : "P";
        for (int i = 0; i < 5; i++) drive_char(f[i], rnd);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    vec_t tbl[8];
    ch_t  junk[16];

    initial begin
        tbl[0] = '{"1230P", 1, 0, 20'h1230C};
        tbl[1] = '{"13",    0, 1, 20'h1230C};
        tbl[2] = '{"0745A", 1, 0, 20'h0745A};
        tbl[3] = '{" 905A", 1, 0, 20'hD905A};
        tbl[4] = '{"0000A", 0, 3, 20'hD905A};
        tbl[5] = '{"1260A", 0, 2, 20'hD905A};
        tbl[6] = '{"1230X", 0, 1, 20'hD905A};
        tbl[7] = '{"1159P", 1, 0, 20'h1159C};
        junk = '{"0", "1", "2", "3", "5", "6", "9", " ", "A", "P", "X", "a",
                 8'h00, 8'hFF, "1", "0"};

        // Reset
        #1 RESETN = 1'b0;
        model_reset();
        #1;
        check("reset_time", 32'({HOUR_T, HOUR_U, MIN_T, MIN_U, AMPM}), 32'h1200A);
        check("reset_ready", 32'(CHAR_READY), 32'h1);
        check("reset_pulses", 32'({TIME_VALID, ERR}), 32'h0);
        @(negedge CLK);
        #1;
        @(negedge CLK);
        #1 RESETN = 1'b1;

        // Table of directed frames, one character per cycle
        for (int v = 0; v < 8; v++) begin
            clear_counts();
            send_str(tbl[v].s, 1'b0);
            idle(4);
            check({"tbl_tv_", tbl[v].s}, 32'(tv_seen), 32'(tbl[v].n_tv));
            check({"tbl_err_", tbl[v].s}, 32'(err_seen), 32'(tbl[v].n_err));
            check({"tbl_stall_", tbl[v].s}, 32'(rdy_low_seen), 32'(tbl[v].n_tv));
            check({"tbl_time_", tbl[v].s}, 32'({HOUR_T, HOUR_U, MIN_T, MIN_U, AMPM}), 32'(tbl[v].t));
        end

        // Reset mid-frame, then first character on the first edge after release
        clear_counts();
        send_str("11", 1'b0);
        RESETN = 1'b0;
        model_reset();
        #1;
        check("midreset_time", 32'({HOUR_T, HOUR_U, MIN_T, MIN_U, AMPM}), 32'h1200A);
        check("midreset_pulses", 32'({TIME_VALID, ERR}), 32'h0);
        CHAR_VALID = 1'b0;
        @(negedge CLK);
        #1;
        @(negedge CLK);
        #1 RESETN = 1'b1;
        send_str("0130P", 1'b0);
        idle(4);
        check("post_reset_time", 32'({HOUR_T, HOUR_U, MIN_T, MIN_U, AMPM}), 32'h0130C);
        check("post_reset_tv", 32'(tv_seen), 32'd1);
        check("post_reset_err", 32'(err_seen), 32'd0);

        // Back-to-back frames: continuous valid, then randomly toggled valid
        clear_counts();
        send_str("0945P1158A", 1'b0);
        idle(4);
        check("b2b_time", 32'({HOUR_T, HOUR_U, MIN_T, MIN_U, AMPM}), 32'h1158A);
        check("b2b_tv", 32'(tv_seen), 32'd2);
        check("b2b_stall", 32'(rdy_low_seen), 32'd2);
        clear_counts();
        send_str("1007A0359P", 1'b1);
        idle(4);
        check("b2b_rnd_time", 32'({HOUR_T, HOUR_U, MIN_T, MIN_U, AMPM}), 32'h0359C);
        check("b2b_rnd_tv", 32'(tv_seen), 32'd2);
        check("b2b_rnd_err", 32'(err_seen), 32'd0);

        // Random legal frames, random junk, then continuous legal frames
        for (int i = 0; i < 25; i++) send_rand_frame(1'b1);
        for (int i = 0; i < 60; i++) drive_char(junk[$urandom_range(0, 15)], 1'b1);
        send_str("X", 1'b0);
        for (int i = 0; i < 10; i++) send_rand_frame(1'b0);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ch3_wt_encoder.md
CH3_WT_ENCODER -- requirements
Module: CH3_WT_ENCODER

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 The block SHALL have these ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  asynchronous active-low reset.
- CHAR_IN  input  8  ASCII character.
- CHAR_VALID  input  1  CHAR_IN is valid.
- CHAR_READY  output  1  block can accept a character.
- HOUR_T  output  4  hour-tens code.
- HOUR_U  output  4  hour-units code.
- MIN_T  output  4  minute-tens code.
- MIN_U  output  4  minute-units code.
- AMPM  output  4  meridiem code.
- TIME_VALID  output  1  one-cycle pulse: a new time has been committed.
- ERR  output  1  one-cycle pulse: the frame was rejected.
REQ-003 The block SHALL have no parameters.

Function
REQ-004 A character SHALL be accepted only on a rising CLK edge where CHAR_VALID=1 and CHAR_READY=1.
REQ-005 Character encoding SHALL be:
- 0x30-0x39 -> 4'h0-4'h9.
- 0x41 'A' -> 4'b1010.
- 0x50 'P' -> 4'b1100.
- 0x20 ' ' -> 4'b1101.
- Any other byte is illegal.
REQ-006 A frame SHALL be exactly 5 accepted characters, in this order: hour-tens, hour-units, minute-tens, minute-units, meridiem.
REQ-007 The FSM SHALL have six states:
- S_HT, S_HU, S_MT, S_MU, S_AP: one per frame position.
- S_DONE: commit cycle.
REQ-008 The FSM SHALL advance one state per accepted legal character and SHALL hold its state when no character is accepted.
REQ-009 Legality per position SHALL be:
- S_HT: ' ', '0' or '1'.
- S_HU: '0'-'9'.
- S_MT: '0'-'5'.
- S_MU: '0'-'9'.
- S_AP: 'A' or 'P'.
REQ-010 At S_HU the hour SHALL be range-checked and rejected unless 1..12:
- Tens ' ' or '0' with units '0' -> reject.
- Tens '1' with units >'2' -> reject.
REQ-011 Accepted codes SHALL be held in shadow registers; HOUR_T, HOUR_U, MIN_T, MIN_U and AMPM SHALL change only on the commit edge.
REQ-012 On the edge accepting a legal meridiem character, the FSM SHALL enter S_DONE.
REQ-013 In S_DONE, on the next edge, the block SHALL copy the shadow registers to the outputs, assert TIME_VALID for exactly one cycle, and return to S_HT.
REQ-014 Latency: TIME_VALID SHALL be high in the second cycle after the 5th character is accepted, coincident with the new output values.
REQ-015 CHAR_READY SHALL equal (state != S_DONE); CHAR_VALID arriving during S_DONE SHALL be held off, not dropped.
REQ-016 On acceptance of an illegal or out-of-range character at any position:
- ERR is registered high for exactly one cycle, on the following cycle.
- The FSM returns to S_HT.
- Shadow contents are discarded.
- Committed outputs are unchanged.
- The offending character is consumed, not re-parsed.
REQ-017 ERR and TIME_VALID SHALL never be high in the same cycle.
REQ-018 HOUR_T SHALL carry the received code unchanged, so ' ' yields 4'b1101 (blank) and '0' yields 4'h0.
REQ-019 Back-to-back frames with CHAR_VALID held high SHALL be accepted, with exactly one stall cycle (the S_DONE cycle) per frame.

Reset
REQ-020 While RESETN=0, the block SHALL force, asynchronously:
- state = S_HT.
- HOUR_T = 4'h1, HOUR_U = 4'h2, MIN_T = 4'h0, MIN_U = 4'h0, AMPM = 4'b1010 (12:00 A).
- TIME_VALID = 0, ERR = 0.
- Shadow registers cleared.
- CHAR_READY = 1.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame, with no TIME_VALID or ERR pulse generated.
REQ-022 Reset release SHALL be synchronous to CLK; the first character SHALL be acceptable on the first rising edge after RESETN goes high.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- "1230P" at one character per cycle -> TIME_VALID pulse; HOUR_T=1, HOUR_U=2, MIN_T=3, MIN_U=0, AMPM=4'b1100; CHAR_READY low exactly one cycle.
- " 905A" -> HOUR_T=4'b1101, HOUR_U=9, MIN_T=0, MIN_U=5, AMPM=4'b1010; ERR never high.
- "1230P", then "13" -> ERR one cycle after '3'; outputs stay 12:30 P; the following "0745A" commits 07:45 A.
- "0000A" -> ERR after 2nd char; "1260A" -> ERR after '6'; "1230X" -> ERR after 'X'; no TIME_VALID in any case.
- Two frames, CHAR_VALID continuously high, CHAR_VALID toggled randomly -> both frames commit correctly; no character lost or duplicated; one stall per frame.
- RESETN pulsed low after "11" of a frame -> outputs 12:00 A immediately; no pulses; a fresh "0130P" commits 01:30 P.
